// File: rtl/adder_result_stage.sv
// Capture stage behind the carry-select adder: buffers {sum, cout, of} results in a small FIFO
// with zero/negative tags, and keeps saturating overflow and carry-out event counters.
module adder_result_stage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_sum,
   input  logic                       in_cout,
   input  logic                       in_of,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_sum,
   output logic                       out_cout,
   output logic                       out_of,
   output logic                       out_zero,
   output logic                       out_neg,
   output logic [$clog2(DEPTH):0]     level,
   input  logic                       clr_stats,
   output logic [CNT_W-1:0]           ovf_count,
   output logic [CNT_W-1:0]           cout_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             of;
      logic             zero;
      logic             neg;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   entry_t           head;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [CNT_W-1:0] ovf_q, ovf_d;
   logic [CNT_W-1:0] cout_q, cout_d;
   logic             push;
   logic             pop;

   // Ready depends only on the registered level, so a full FIFO never accepts even when popping.
   assign in_ready  = (level_q != LW'(DEPTH));
   assign out_valid = (level_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      cout_d   = cout_q;

      if (push) begin
         mem_d[wr_ptr_q] = '{sum:  in_sum,
                             cout: in_cout,
                             of:   in_of,
                             zero: (in_sum == '0),
                             neg:  in_sum[WIDTH-1]};
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // Clear wins over a same-cycle increment; counters stick at all-ones.
      if (clr_stats) begin
         ovf_d  = '0;
         cout_d = '0;
      end else if (push) begin
         if (in_of && (ovf_q != '1)) begin
            ovf_d = ovf_q + CNT_W'(1);
         end
         if (in_cout && (cout_q != '1)) begin
            cout_d = cout_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= '0;
         cout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         cout_q   <= cout_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Storage is not reset; gating the head on level hides stale entries after reset or drain.
   assign head       = out_valid ? mem_q[rd_ptr_q] : '0;
   assign out_sum    = head.sum;
   assign out_cout   = head.cout;
   assign out_of     = head.of;
   assign out_zero   = head.zero;
   assign out_neg    = head.neg;
   assign level      = level_q;
   assign ovf_count  = ovf_q;
   assign cout_count = cout_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Randomized and directed bench for adder_result_stage, checked against a queue-based model.
module tb_adder_result_stage;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_sum;
   logic             in_cout;
   logic             in_of;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_of;
   logic             out_zero;
   logic             out_neg;
   logic [2:0]       level;
   logic             clr_stats;
   logic [CNT_W-1:0] ovf_count;
   logic [CNT_W-1:0] cout_count;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             of;
   } ent_t;

   ent_t mq[$];
   int   ovfM;
   int   coutM;
   int   vecCount;
   int   missCount;

   adder_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .in_cout    (in_cout),
      .in_of      (in_of),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_cout   (out_cout),
      .out_of     (out_of),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .level      (level),
      .clr_stats  (clr_stats),
      .ovf_count  (ovf_count),
      .cout_count (cout_count)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Compare every output against the model's current view of the FIFO and counters.
   task automatic checkAll();
      checkOutput("level", 64'(level), 64'(mq.size()));
      checkOutput("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
      checkOutput("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         checkOutput("out_sum", 64'(out_sum), 64'(mq[0].sum));
         checkOutput("out_cout", 64'(out_cout), 64'(mq[0].cout));
         checkOutput("out_of", 64'(out_of), 64'(mq[0].of));
         checkOutput("out_zero", 64'(out_zero), 64'(mq[0].sum == 0));
         checkOutput("out_neg", 64'(out_neg), 64'(mq[0].sum[WIDTH-1]));
      end else begin
         checkOutput("out_sum_empty", 64'(out_sum), 64'd0);
         checkOutput("out_flags_empty", 64'({out_cout, out_of, out_zero, out_neg}), 64'd0);
      end
      checkOutput("ovf_count", 64'(ovf_count), 64'(ovfM));
      checkOutput("cout_count", 64'(cout_count), 64'(coutM));
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] s, input logic c,
                                input logic o, input logic r, input logic clr);
      bit   doPush;
      bit   doPop;
      ent_t e;
      in_valid  = v;
      in_sum    = v ? s : 'x;
      in_cout   = v ? c : 1'bx;
      in_of     = v ? o : 1'bx;
      out_ready = r;
      clr_stats = clr;
      doPush = v && (mq.size() < DEPTH);
      doPop  = (mq.size() > 0) && r;
      @(posedge clk);
      #1;
      if (doPop) void'(mq.pop_front());
      if (doPush) begin
         e.sum  = s;
         e.cout = c;
         e.of   = o;
         mq.push_back(e);
      end
      if (clr) begin
         ovfM  = 0;
         coutM = 0;
      end else if (doPush) begin
         ovfM  = (ovfM + int'(o) > CMAX) ? CMAX : ovfM + int'(o);
         coutM = (coutM + int'(c) > CMAX) ? CMAX : coutM + int'(c);
      end
      checkAll();
   endtask

   initial begin
      logic [WIDTH-1:0] fillSums [4];
      vecCount  = 0;
      missCount = 0;
      ovfM      = 0;
      coutM     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sum    = '0;
      in_cout   = 1'b0;
      in_of     = 1'b0;
      out_ready = 1'b0;
      clr_stats = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkAll();
      rst = 1'b0;
      #1;
      checkOutput("ready_after_reset", 64'(in_ready), 64'd1);

      // Single push of a negative value, then pop it.
      applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("single_neg", 64'({out_valid, out_neg, out_zero}), 64'b110);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("single_drained", 64'({out_valid, level}), 64'd0);

      // Fill while stalled, then drain in order.
      fillSums[0] = 32'h1FFF_FFFE;
      fillSums[1] = 32'h0000_07A9;
      fillSums[2] = 32'h0000_015F;
      fillSums[3] = 32'h0000_0000;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, fillSums[i], 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("full_ready", 64'({in_ready, level}), 64'({1'b0, 3'd4}));
      for (int i = 0; i < 4; i++) begin
         checkOutput("drain_order", 64'(out_sum), 64'(fillSums[i]));
         if (i == 3) checkOutput("zero_at_head", 64'(out_zero), 64'd1);
         applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      end

      // Full with simultaneous offer and pop: offer must be dropped.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i + 100), 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("full_pop_level", 64'({in_ready, level}), 64'({1'b1, 3'd3}));
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("full_pop_empty", 64'(level), 64'd0);

      // Streaming push and pop every cycle.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 32'(32'h1000 + i), 1'b0, 1'b0, 1'b1, 1'b0);
         checkOutput("stream_level", 64'(level), 64'd1);
         checkOutput("stream_sum", 64'(out_sum), 64'(32'h1000 + i));
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Counter saturation and clear priority.
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 17; i++) applyStimulus(1'b1, 32'(i), 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("ovf_saturated", 64'(ovf_count), 64'd15);
      checkOutput("cout_saturated", 64'(cout_count), 64'd15);
      applyStimulus(1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("clr_priority", 64'({ovf_count, cout_count}), 64'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 15) == 0));
      end
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset mid-cycle with three entries queued.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(i + 7), 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("pre_reset_level", 64'(level), 64'd3);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      mq.delete();
      ovfM  = 0;
      coutM = 0;
      checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
      checkOutput("async_rst_level", 64'(level), 64'd0);
      checkOutput("async_rst_counts", 64'({ovf_count, cout_count}), 64'd0);
      checkOutput("async_rst_sum", 64'(out_sum), 64'd0);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("ready_after_release", 64'(in_ready), 64'd1);
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
